// File: rtl/wb_pkg.sv
// Shared state encoding and funct3 load codes for the registered writeback stage.
package wb_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: selects byte/half/word from an aligned memory word
// and sign- or zero-extends it to XLEN according to funct3.
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] fmt_data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] sel_w;

    // The extension bit is the lane's MSB only for signed loads; the signed cast then widens.
    function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
        logic signed [8:0] t;
        t = {sgn & v[7], v};
        return XLEN'(t);
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
        logic signed [16:0] t;
        t = {sgn & v[15], v};
        return XLEN'(t);
    endfunction

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic signed [32:0] t;
        t = {sgn & v[31], v};
        return XLEN'(t);
    endfunction

    generate
        if (XLEN == 64) begin : g_x64
            always_comb begin
                sel_b = raw[{offset, 3'b000} +: 8];
                sel_h = raw[{offset[2:1], 4'b0000} +: 16];
                sel_w = raw[{offset[2], 5'b00000} +: 32];
            end
        end else begin : g_x32
            logic unused_off2;
            assign unused_off2 = offset[2];
            always_comb begin
                sel_b = raw[{offset[1:0], 3'b000} +: 8];
                sel_h = raw[{offset[1], 4'b0000} +: 16];
                sel_w = raw[31:0];
            end
        end
    endgenerate

    always_comb begin
        fmt_data = raw;
        case (funct3)
            F3_LB:   fmt_data = ext8(sel_b, 1'b1);
            F3_LBU:  fmt_data = ext8(sel_b, 1'b0);
            F3_LH:   fmt_data = ext16(sel_h, 1'b1);
            F3_LHU:  fmt_data = ext16(sel_h, 1'b0);
            F3_LW:   fmt_data = ext32(sel_w, 1'b1);
            F3_LWU:  fmt_data = ext32(sel_w, 1'b0);
            F3_LD:   fmt_data = raw;
            default: fmt_data = raw;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Registered writeback stage with variable-latency load handshake and timeout.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int PC_INC      = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_regwrite,
    input  logic                  in_memtoreg,
    input  logic                  in_jal,
    input  logic                  in_jalr,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  mem_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           retire_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    wb_state_e             state_q, state_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;

    logic [REG_ADDR_W-1:0] rd_p1;
    logic                  regwrite_p1;
    logic [2:0]            f3_p1;
    logic [2:0]            off_p1;

    logic                  cap_en;
    logic                  done_p0;
    logic                  err_p0;
    logic                  vld_p0;
    logic                  regwrite_p0;
    logic [REG_ADDR_W-1:0] addr_p0;
    logic [XLEN-1:0]       data_p0;
    logic [2:0]            fmt_f3;
    logic [2:0]            fmt_off;
    logic [XLEN-1:0]       fmt_data;
    logic [XLEN-1:0]       link_val;

    assign in_ready = (state_q == IDLE);
    assign link_val = in_pc + XLEN'(PC_INC);

    wb_load_fmt #(
        .XLEN (XLEN)
    ) u_load_fmt (
        .funct3   (fmt_f3),
        .offset   (fmt_off),
        .raw      (mem_rdata),
        .fmt_data (fmt_data)
    );

    // One formatter is shared: it sees the live instruction in IDLE, the captured load in WAIT_MEM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_en      = 1'b0;
        done_p0     = 1'b0;
        err_p0      = 1'b0;
        fmt_f3      = in_funct3;
        fmt_off     = in_alu_result[2:0];
        regwrite_p0 = in_regwrite;
        addr_p0     = in_rd;
        data_p0     = in_alu_result;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_memtoreg && !mem_rvalid) begin
                        state_d = WAIT_MEM;
                        cnt_d   = '0;
                        cap_en  = 1'b1;
                    end else begin
                        done_p0 = 1'b1;
                        if (in_memtoreg) begin
                            data_p0 = fmt_data;
                        end else if (in_jal || in_jalr) begin
                            data_p0 = link_val;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                fmt_f3      = f3_p1;
                fmt_off     = off_p1;
                regwrite_p0 = regwrite_p1;
                addr_p0     = rd_p1;
                data_p0     = fmt_data;
                // Data arriving on the final allowed cycle still wins over the abort.
                if (mem_rvalid) begin
                    done_p0 = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_p0  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_p0 = done_p0 && regwrite_p0 && (addr_p0 != '0);
    end

    // Stage boundary: control state and captured load fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_p1       <= '0;
            regwrite_p1 <= 1'b0;
            f3_p1       <= '0;
            off_p1      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap_en) begin
                rd_p1       <= in_rd;
                regwrite_p1 <= in_regwrite;
                f3_p1       <= in_funct3;
                off_p1      <= in_alu_result[2:0];
            end
        end
    end

    // Stage boundary: register-file write port and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            mem_err  <= 1'b0;
        end else begin
            rf_we   <= vld_p0;
            mem_err <= err_p0;
            if (vld_p0) begin
                rf_waddr <= addr_p0;
                rf_wdata <= data_p0;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Stage boundary: retirement count, including suppressed rd=0 writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (done_p0) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases plus randomized traffic against a
// transaction-level reference model.
module tb_wb_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_regwrite, in_memtoreg, in_jal, in_jalr;
    logic [2:0]      in_funct3;
    logic [RW-1:0]   in_rd;
    logic [XLEN-1:0] in_alu_result, in_pc;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            mem_err;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     retire_cnt;
`endif

    always #5 clk = ~clk;

    wb_unit #(
        .XLEN        (XLEN),
        .REG_ADDR_W  (RW),
        .PC_INC      (4),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_jal        (in_jal),
        .in_jalr       (in_jalr),
        .in_funct3     (in_funct3),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .mem_err       (mem_err)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        rvalid;
        logic [31:0] rdata;
    } stim_t;

    int n_errs;
    int n_checks;

    // Reference model: a pending-load record and the expected output values.
    bit          m_busy;
    int          m_waited;
    stim_t       m_pend;
    logic        m_we, m_err;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [63:0] m_retire;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((rdata >> (8 * off)) & 32'hFF);
                if (f3 == 3'b000 && v > 127) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((rdata >> (16 * off[1])) & 32'hFFFF);
                if (f3 == 3'b001 && v > 32767) v = v - 65536;
            end
            default: v = longint'(rdata);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_data(input stim_t s);
        if (s.memtoreg) return ref_load(s.f3, s.alu[1:0], s.rdata);
        if (s.jal || s.jalr) return s.pc + 32'd4;
        return s.alu;
    endfunction

    task automatic m_complete(input logic regwrite, input logic [4:0] rd, input logic [31:0] data);
        m_retire = m_retire + 64'd1;
        if (regwrite && rd != 5'd0) begin
            m_we    = 1'b1;
            m_waddr = rd;
            m_wdata = data;
        end
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_waited = 0;
        m_pend   = '0;
        m_we     = 1'b0;
        m_err    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_retire = '0;
    endtask

    task automatic model_step(input stim_t s);
        m_we  = 1'b0;
        m_err = 1'b0;
        if (!m_busy) begin
            if (s.valid) begin
                if (s.memtoreg && !s.rvalid) begin
                    m_busy   = 1;
                    m_pend   = s;
                    m_waited = 0;
                end else begin
                    m_complete(s.regwrite, s.rd, ref_data(s));
                end
            end
        end else begin
            m_waited++;
            if (s.rvalid) begin
                m_busy = 0;
                m_complete(m_pend.regwrite, m_pend.rd, ref_load(m_pend.f3, m_pend.alu[1:0], s.rdata));
            end else if (m_waited == TMO) begin
                m_busy = 0;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        in_valid      = s.valid;
        in_regwrite   = s.regwrite;
        in_memtoreg   = s.memtoreg;
        in_jal        = s.jal;
        in_jalr       = s.jalr;
        in_funct3     = s.f3;
        in_rd         = s.rd;
        in_alu_result = s.alu;
        in_pc         = s.pc;
        mem_rvalid    = s.rvalid;
        mem_rdata     = s.rdata;
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic cyc(input stim_t s);
        check("in_ready", 64'(in_ready), 64'(!m_busy));
        drive(s);
        model_step(s);
        @(negedge clk);
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("mem_err", 64'(mem_err), 64'(m_err));
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, m_retire);
`endif
    endtask

    function automatic stim_t mk(input logic memtoreg, input logic jal, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc,
                                 input logic rvalid, input logic [31:0] rdata);
        stim_t s;
        s = '0;
        s.valid = 1'b1; s.regwrite = 1'b1; s.memtoreg = memtoreg; s.jal = jal;
        s.f3 = f3; s.rd = rd; s.alu = alu; s.pc = pc; s.rvalid = rvalid; s.rdata = rdata;
        return s;
    endfunction

    function automatic stim_t idle(input logic rvalid, input logic [31:0] rdata);
        stim_t s;
        s = '0;
        s.rvalid = rvalid;
        s.rdata  = rdata;
        return s;
    endfunction

    initial begin
        stim_t s;
        n_errs   = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        drive('0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_err", 64'(mem_err), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        cyc(mk(1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 32'h0));
        check("alu_lit", 64'(rf_wdata), 64'h1234);
        cyc(idle(1'b0, 32'h0));
        check("alu_we_drop", 64'(rf_we), 64'd0);

        cyc(mk(1'b0, 1'b1, 3'b000, 5'd1, 32'h0, 32'h0000_0100, 1'b0, 32'h0));
        check("jal_lit", 64'(rf_wdata), 64'h104);
        cyc(mk(1'b0, 1'b1, 3'b000, 5'd1, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0));
        check("jal_wrap", 64'(rf_wdata), 64'h0);

        cyc(mk(1'b1, 1'b0, 3'b000, 5'd3, 32'h0000_0003, 32'h0, 1'b1, 32'h80FF_0000));
        check("lb_lit", 64'(rf_wdata), 64'hFFFF_FF80);
        cyc(mk(1'b1, 1'b0, 3'b100, 5'd3, 32'h0000_0003, 32'h0, 1'b1, 32'h80FF_0000));
        check("lbu_lit", 64'(rf_wdata), 64'h0000_0080);
        cyc(mk(1'b1, 1'b0, 3'b001, 5'd4, 32'h0000_0002, 32'h0, 1'b1, 32'h80FF_0000));
        check("lh_lit", 64'(rf_wdata), 64'hFFFF_80FF);

        // Delayed load: data three cycles after accept.
        cyc(mk(1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0040, 32'h0, 1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b1, 32'hDEAD_BEEF));
        check("dly_we", 64'(rf_we), 64'd1);
        check("dly_data", 64'(rf_wdata), 64'hDEAD_BEEF);
        cyc(idle(1'b0, 32'h0));

        // Timeout with a foreign instruction offered while busy.
        cyc(mk(1'b1, 1'b0, 3'b010, 5'd9, 32'h0000_0080, 32'h0, 1'b0, 32'h0));
        cyc(mk(1'b0, 1'b0, 3'b000, 5'd11, 32'h7777_7777, 32'h0, 1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        check("tmo_err", 64'(mem_err), 64'd1);
        check("tmo_we", 64'(rf_we), 64'd0);
        cyc(idle(1'b0, 32'h0));
        check("tmo_err_drop", 64'(mem_err), 64'd0);

        // Data on the last allowed cycle.
        cyc(mk(1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_0000, 32'h0, 1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        cyc(idle(1'b1, 32'h1234_5678));
        check("last_we", 64'(rf_we), 64'd1);
        check("last_err", 64'(mem_err), 64'd0);

        cyc(mk(1'b0, 1'b0, 3'b000, 5'd0, 32'h0000_ABCD, 32'h0, 1'b0, 32'h0));
        check("rd0_we", 64'(rf_we), 64'd0);

        // Asynchronous reset in the middle of a pending load.
        cyc(mk(1'b0, 1'b0, 3'b000, 5'd12, 32'h5555_AAAA, 32'h0, 1'b0, 32'h0));
        cyc(mk(1'b1, 1'b0, 3'b010, 5'd13, 32'h0000_0000, 32'h0, 1'b0, 32'h0));
        cyc(idle(1'b0, 32'h0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_waddr", 64'(rf_waddr), 64'd0);
        check("arst_wdata", 64'(rf_wdata), 64'd0);
        check("arst_we", 64'(rf_we), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        check("arst_cnt", retire_cnt, 64'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(idle(1'b1, 32'hCAFE_F00D));
        check("late_rvalid", 64'(rf_we), 64'd0);

        for (int i = 0; i < 600; i++) begin
            s.valid    = ($urandom_range(0, 9) < 7);
            s.regwrite = ($urandom_range(0, 9) < 8);
            s.memtoreg = ($urandom_range(0, 9) < 4);
            s.jal      = ($urandom_range(0, 9) == 0);
            s.jalr     = ($urandom_range(0, 9) == 0);
            s.f3       = 3'($urandom_range(0, 7));
            s.rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            s.alu      = $urandom;
            s.pc       = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            s.rvalid   = ($urandom_range(0, 9) < 3);
            s.rdata    = $urandom;
            cyc(s);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
